rt_frag_stream: RTL and testbench



---
 rtl/rt_pkg.sv | 23 ++
 rtl/rt_frag_fifo.sv | 67 ++++++
 rtl/rt_rgu.sv | 40 ++++
 rtl/rt_frag_stream.sv | 227 ++++++++++++++++++++++
 tb/tb_rt_frag_stream.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rt_pkg.sv
// Shared render-loop types and camera fixed-point constants.
// RT_FRAG_COORD_EN adds pixel coordinates to each fragment entry.
package rt_pkg;

    localparam int unsigned CAMERA_IW = 16;
    localparam int unsigned CAMERA_QW = 16;
    localparam int unsigned CAMERA_WL = CAMERA_IW + CAMERA_QW;

    typedef logic [1:0] rt_frag_state_t;
    localparam rt_frag_state_t StIdle  = 2'd0;
    localparam rt_frag_state_t StRun   = 2'd1;
    localparam rt_frag_state_t StDrain = 2'd2;

    typedef struct packed {
        logic [31:0]          data;
        logic                 last;
`ifdef RT_FRAG_COORD_EN
        logic [CAMERA_IW-1:0] x;
        logic [CAMERA_IW-1:0] y;
`endif
    } rt_frag_t;

endpackage

// File: rtl/rt_frag_fifo.sv
// Synchronous FIFO with occupancy count and synchronous flush.
// Depth must be a power of two so the pointers wrap naturally.
module rt_frag_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 4,
    localparam int unsigned AW = $clog2(Depth),
    localparam int unsigned CW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(Depth));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so push into a full FIFO is legal then.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/rt_rgu.sv
// Ray generation unit: direction from the camera centre to the centre of pixel (x, y).
// Pixel coordinates are integers; all vectors are Q(IW.QW) fixed point.
module rt_rgu import rt_pkg::*; #(
    parameter int unsigned IW = CAMERA_IW,
    parameter int unsigned WL = CAMERA_WL
) (
    input  logic [IW-1:0] pixel_x,
    input  logic [IW-1:0] pixel_y,
    input  logic [WL-1:0] camera_center_x,
    input  logic [WL-1:0] camera_center_y,
    input  logic [WL-1:0] camera_center_z,
    input  logic [WL-1:0] pixel_delta_u_x,
    input  logic [WL-1:0] pixel_delta_u_y,
    input  logic [WL-1:0] pixel_delta_u_z,
    input  logic [WL-1:0] pixel_delta_v_x,
    input  logic [WL-1:0] pixel_delta_v_y,
    input  logic [WL-1:0] pixel_delta_v_z,
    input  logic [WL-1:0] pixel_00_loc_x,
    input  logic [WL-1:0] pixel_00_loc_y,
    input  logic [WL-1:0] pixel_00_loc_z,
    output logic [WL-1:0] ray_direction_x,
    output logic [WL-1:0] ray_direction_y,
    output logic [WL-1:0] ray_direction_z
);

    logic [WL-1:0] px;
    logic [WL-1:0] py;

    // Integer pixel index times a Q delta stays in Q format; products wrap to WL bits.
    assign px = WL'(pixel_x);
    assign py = WL'(pixel_y);

    assign ray_direction_x = pixel_00_loc_x + px * pixel_delta_u_x + py * pixel_delta_v_x
                             - camera_center_x;
    assign ray_direction_y = pixel_00_loc_y + px * pixel_delta_u_y + py * pixel_delta_v_y
                             - camera_center_y;
    assign ray_direction_z = pixel_00_loc_z + px * pixel_delta_u_z + py * pixel_delta_v_z
                             - camera_center_z;

endmodule

// File: rtl/rt_frag_stream.sv
// Raster-scan fragment generator: rt_rgu -> LAT-stage pipeline -> FIFO -> valid/ready stream.
// Define RT_FRAG_COORD_EN to carry pixel coordinates on m_x/m_y alongside each beat.
module rt_frag_stream import rt_pkg::*; #(
    parameter int unsigned IW         = CAMERA_IW,
    parameter int unsigned QW         = CAMERA_QW,
    parameter int unsigned LAT        = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    input  logic [31:0]   image_width,
    input  logic [31:0]   image_height,
    input  logic [31:0]   camera_center_x,
    input  logic [31:0]   camera_center_y,
    input  logic [31:0]   camera_center_z,
    input  logic [31:0]   pixel_delta_u_x,
    input  logic [31:0]   pixel_delta_u_y,
    input  logic [31:0]   pixel_delta_u_z,
    input  logic [31:0]   pixel_delta_v_x,
    input  logic [31:0]   pixel_delta_v_y,
    input  logic [31:0]   pixel_delta_v_z,
    input  logic [31:0]   pixel_00_loc_x,
    input  logic [31:0]   pixel_00_loc_y,
    input  logic [31:0]   pixel_00_loc_z,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [31:0]   m_data,
    output logic          m_last
`ifdef RT_FRAG_COORD_EN
    ,
    output logic [IW-1:0] m_x,
    output logic [IW-1:0] m_y
`endif
);

    localparam int unsigned WL = IW + QW;
    localparam int unsigned FW = $bits(rt_frag_t);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(FIFO_DEPTH + LAT + 2);

    rt_frag_state_t state_q, state_d;
    logic [IW-1:0]  w_q, w_d, h_q, h_d;
    logic [IW-1:0]  x_q, x_d, y_q, y_d;
    logic [IW-1:0]  img_w, img_h;
    logic           done_q, done_d;
    logic           issue, issue_last, can_issue, pop;
    logic [OW-1:0]  inflight;
    logic [WL-1:0]  ray_x, ray_y, ray_z;
    logic [31:0]    ray_data;
    rt_frag_t       issue_frag, head;
    rt_frag_t       pipe_q [LAT];
    logic [LAT-1:0] pipe_valid_q;
    logic [FW-1:0]  fifo_rdata;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty, fifo_full;
    logic           unused_bits;

    assign img_w = image_width[QW +: IW];
    assign img_h = image_height[QW +: IW];
    assign unused_bits = ^{image_width, image_height, ray_y, ray_z, fifo_full};

    rt_rgu #(
        .IW (IW),
        .WL (WL)
    ) u_rgu (
        .pixel_x         (x_q),
        .pixel_y         (y_q),
        .camera_center_x (camera_center_x[WL-1:0]),
        .camera_center_y (camera_center_y[WL-1:0]),
        .camera_center_z (camera_center_z[WL-1:0]),
        .pixel_delta_u_x (pixel_delta_u_x[WL-1:0]),
        .pixel_delta_u_y (pixel_delta_u_y[WL-1:0]),
        .pixel_delta_u_z (pixel_delta_u_z[WL-1:0]),
        .pixel_delta_v_x (pixel_delta_v_x[WL-1:0]),
        .pixel_delta_v_y (pixel_delta_v_y[WL-1:0]),
        .pixel_delta_v_z (pixel_delta_v_z[WL-1:0]),
        .pixel_00_loc_x  (pixel_00_loc_x[WL-1:0]),
        .pixel_00_loc_y  (pixel_00_loc_y[WL-1:0]),
        .pixel_00_loc_z  (pixel_00_loc_z[WL-1:0]),
        .ray_direction_x (ray_x),
        .ray_direction_y (ray_y),
        .ray_direction_z (ray_z)
    );

    if (WL >= 32) begin : g_trunc
        assign ray_data = ray_x[31:0];
    end else begin : g_sext
        assign ray_data = {{(32 - WL){ray_x[WL-1]}}, ray_x};
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + OW'(pipe_valid_q[i]);
        end
    end

    // Every queued or in-flight entry owns a FIFO slot; a pop this cycle returns one.
    assign pop        = ~fifo_empty & m_ready;
    assign can_issue  = (OW'(fifo_count) + inflight) < (OW'(FIFO_DEPTH) + OW'(pop));
    assign issue      = (state_q == StRun) & ~abort & can_issue;
    assign issue_last = (x_q == w_q - IW'(1)) & (y_q == h_q - IW'(1));

    always_comb begin
        issue_frag      = '0;
        issue_frag.data = ray_data;
        issue_frag.last = issue_last;
`ifdef RT_FRAG_COORD_EN
        issue_frag.x    = x_q;
        issue_frag.y    = y_q;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= issue;
            pipe_q[0]       <= issue_frag;
            for (int i = 1; i < LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1] & ~abort;
                pipe_q[i]       <= pipe_q[i-1];
            end
        end
    end

    rt_frag_fifo #(
        .Width (FW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (abort),
        .push   (pipe_valid_q[LAT-1]),
        .wdata  (pipe_q[LAT-1]),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign head = rt_frag_t'(fifo_rdata);

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        w_d = img_w;
                        h_d = img_h;
                        x_d = '0;
                        y_d = '0;
                        if (img_w != '0 && img_h != '0) begin
                            state_d = StRun;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (issue) begin
                        if (issue_last) begin
                            state_d = StDrain;
                        end else if (x_q == w_q - IW'(1)) begin
                            x_d = '0;
                            y_d = y_q + IW'(1);
                        end else begin
                            x_d = x_q + IW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (pop && head.last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            w_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign m_valid = ~fifo_empty;
    assign m_data  = fifo_empty ? '0 : head.data;
    assign m_last  = ~fifo_empty & head.last;
`ifdef RT_FRAG_COORD_EN
    assign m_x     = fifo_empty ? '0 : head.x;
    assign m_y     = fifo_empty ? '0 : head.y;
`endif

endmodule

// File: tb/tb_rt_frag_stream.sv
// Self-checking bench for rt_frag_stream against a raster-order reference model.
`timescale 1ns/1ps
module tb_rt_frag_stream;

    localparam int LAT        = 3;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        m_ready = 1'b0;
    logic [31:0] image_width = '0;
    logic [31:0] image_height = '0;
    logic [31:0] camera_center_x = '0, camera_center_y = '0, camera_center_z = '0;
    logic [31:0] pixel_delta_u_x = '0, pixel_delta_u_y = '0, pixel_delta_u_z = '0;
    logic [31:0] pixel_delta_v_x = '0, pixel_delta_v_y = '0, pixel_delta_v_z = '0;
    logic [31:0] pixel_00_loc_x = '0, pixel_00_loc_y = '0, pixel_00_loc_z = '0;
    logic        busy, done, m_valid, m_last;
    logic [31:0] m_data;
`ifdef RT_FRAG_COORD_EN
    logic [15:0] m_x, m_y;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rt_frag_stream #(
        .LAT        (LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .start           (start),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .image_width     (image_width),
        .image_height    (image_height),
        .camera_center_x (camera_center_x),
        .camera_center_y (camera_center_y),
        .camera_center_z (camera_center_z),
        .pixel_delta_u_x (pixel_delta_u_x),
        .pixel_delta_u_y (pixel_delta_u_y),
        .pixel_delta_u_z (pixel_delta_u_z),
        .pixel_delta_v_x (pixel_delta_v_x),
        .pixel_delta_v_y (pixel_delta_v_y),
        .pixel_delta_v_z (pixel_delta_v_z),
        .pixel_00_loc_x  (pixel_00_loc_x),
        .pixel_00_loc_y  (pixel_00_loc_y),
        .pixel_00_loc_z  (pixel_00_loc_z),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last)
`ifdef RT_FRAG_COORD_EN
        ,
        .m_x             (m_x),
        .m_y             (m_y)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ray x for pixel (x, y): pixel centre minus camera centre, 32-bit wrapping arithmetic.
    function automatic logic [31:0] ref_ray(input int x, input int y);
        return pixel_00_loc_x + 32'(x) * pixel_delta_u_x + 32'(y) * pixel_delta_v_x
               - camera_center_x;
    endfunction

    task automatic randomize_camera();
        camera_center_x = $urandom; camera_center_y = $urandom; camera_center_z = $urandom;
        pixel_delta_u_x = $urandom; pixel_delta_u_y = $urandom; pixel_delta_u_z = $urandom;
        pixel_delta_v_x = $urandom; pixel_delta_v_y = $urandom; pixel_delta_v_z = $urandom;
        pixel_00_loc_x  = $urandom; pixel_00_loc_y  = $urandom; pixel_00_loc_z  = $urandom;
    endtask

    task automatic set_image(input int w, input int h);
        image_width  = (32'(w) << 16) | 32'($urandom_range(0, 65535));
        image_height = (32'(h) << 16) | 32'($urandom_range(0, 65535));
    endtask

    task automatic idle_check(input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
            check("idle_valid", m_valid, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    // mode 0: ready always; 1: toggling; 2: random; 3: stalled for the first 50 cycles.
    task automatic run_frame(input int w, input int h, input int mode, input int hold_start);
        logic [31:0] exp_q[$];
        logic [31:0] xy_q[$];
        logic [31:0] exp_xy;
        logic [31:0] prev_data;
        logic        prev_last;
        bit          prev_stall, got_last, ended, first_seen;
        int          n, cyc, beats;
        n = w * h;
        randomize_camera();
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                exp_q.push_back(ref_ray(xx, yy));
                xy_q.push_back({16'(xx), 16'(yy)});
            end
        end
        set_image(w, h);
        start = 1'b1;
        @(posedge clk); #1;
        cyc = 0; beats = 0; prev_stall = 0; ended = 0; first_seen = 0;
        prev_data = '0; prev_last = 1'b0;
        while (!ended && cyc < 2000) begin
            if (cyc >= hold_start) start = 1'b0;
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 2 == 0);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = (cyc >= 50);
            endcase
            if (m_valid && !first_seen) begin
                first_seen = 1;
                check("first_beat_latency", cyc, LAT + 1);
            end
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            got_last = 0;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", beats + 1, n);
                end else begin
                    check("beat_data", m_data, exp_q.pop_front());
                    exp_xy = xy_q.pop_front();
`ifdef RT_FRAG_COORD_EN
                    check("beat_x", m_x, exp_xy[31:16]);
                    check("beat_y", m_y, exp_xy[15:0]);
`endif
                    check("beat_last", m_last, exp_q.size() == 0);
                    got_last = (exp_q.size() == 0);
                end
                beats++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            @(posedge clk); #1;
            cyc++;
            check("done_timing", done, got_last);
            if (got_last) begin
                ended = 1;
                check("busy_after_done", busy, 0);
                if (mode == 0) check("done_cycle", cyc, LAT + 1 + n);
            end
        end
        start = 1'b0;
        check("frame_ended", ended, 1);
        check("beat_count", beats, n);
    endtask

    initial begin
        int beats, cyc;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        @(negedge clk) resetn = 1'b1;

        // 4x2 at full rate, then 3x3 under toggling and random backpressure
        run_frame(4, 2, 0, 0);
        idle_check(2);
        run_frame(3, 3, 1, 0);
        run_frame(3, 3, 2, 0);

        // Long stall then release: nothing lost
        run_frame(5, 4, 3, 0);

        // Single pixel frame
        run_frame(1, 1, 0, 0);
        idle_check(2);

        // Zero-sized frames: done pulse only
        set_image(0, 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_w_done", done, 1);
        check("zero_w_busy", busy, 0);
        @(posedge clk); #1;
        check("zero_w_done_end", done, 0);
        idle_check(LAT + 3);
        set_image(2, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_h_done", done, 1);
        check("zero_h_busy", busy, 0);
        idle_check(LAT + 3);

        // start held during RUN is ignored
        run_frame(2, 2, 0, 6);
        idle_check(3);

        // Abort after 5 of 16 beats
        randomize_camera();
        set_image(4, 4);
        m_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < 5 && cyc < 200) begin
            if (m_valid && m_ready) begin
                check("pre_abort_data", m_data, ref_ray(beats % 4, beats / 4));
                beats++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("pre_abort_beats", beats, 5);
        check("pre_abort_busy", busy, 1);
        abort = 1'b1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", m_valid, 0);
        check("abort_last", m_last, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        m_ready = 1'b1;
        repeat (LAT + 3) begin
            @(posedge clk); #1;
            check("post_abort_valid", m_valid, 0);
            check("post_abort_done", done, 0);
        end
        run_frame(4, 4, 2, 0);

        // Reset asserted mid-frame
        randomize_camera();
        set_image(3, 3);
        m_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_valid", m_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_data", m_data, 0);
        check("mid_rst_last", m_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk) resetn = 1'b1;
        run_frame(4, 4, 0, 0);
        idle_check(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
